// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for three requesters (ALU, FPU, MEM) with a register-busy scoreboard.
// Define WB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority ALU > FPU > MEM.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_fmode,
  input  logic [14:0] req_reg,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  output logic        wenable,
  output logic        wfmode,
  output logic [4:0]  wreg,
  output logic [31:0] wdata,
  input  logic        iss_valid,
  input  logic        iss_fmode,
  input  logic [4:0]  iss_reg,
  input  logic        chk_fmode,
  input  logic [4:0]  chk_reg1,
  input  logic [4:0]  chk_reg2,
  output logic        busy1,
  output logic        busy2
);

  logic [2:0]  grant;
  logic        xfer;
  logic        sel_fmode;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;
  logic        sel_x0;
  logic        iss_x0;

  logic        wenable_q, wenable_d;
  logic        wfmode_q,  wfmode_d;
  logic [4:0]  wreg_q,    wreg_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [63:0] sb_q,      sb_d;

`ifdef WB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant = 3'b000;
    if (rstn) begin
      case (rr_ptr_q)
        2'd1: begin
          if (req_valid[1])      grant = 3'b010;
          else if (req_valid[2]) grant = 3'b100;
          else if (req_valid[0]) grant = 3'b001;
        end
        2'd2: begin
          if (req_valid[2])      grant = 3'b100;
          else if (req_valid[0]) grant = 3'b001;
          else if (req_valid[1]) grant = 3'b010;
        end
        default: begin
          if (req_valid[0])      grant = 3'b001;
          else if (req_valid[1]) grant = 3'b010;
          else if (req_valid[2]) grant = 3'b100;
        end
      endcase
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant[0])      rr_ptr_d = 2'd1;
    else if (grant[1]) rr_ptr_d = 2'd2;
    else if (grant[2]) rr_ptr_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) rr_ptr_q <= 2'd0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    grant = 3'b000;
    if (rstn) begin
      if (req_valid[0])      grant = 3'b001;
      else if (req_valid[1]) grant = 3'b010;
      else if (req_valid[2]) grant = 3'b100;
    end
  end
`endif

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    sel_fmode = req_fmode[0];
    sel_reg   = req_reg[4:0];
    sel_data  = req_data[31:0];
    if (grant[1]) begin
      sel_fmode = req_fmode[1];
      sel_reg   = req_reg[9:5];
      sel_data  = req_data[63:32];
    end else if (grant[2]) begin
      sel_fmode = req_fmode[2];
      sel_reg   = req_reg[14:10];
      sel_data  = req_data[95:64];
    end
  end

  // Integer x0 is hardwired zero; float f0 is an ordinary register.
  assign sel_x0 = !sel_fmode && (sel_reg == 5'd0);
  assign iss_x0 = !iss_fmode && (iss_reg == 5'd0);

  always_comb begin
    wenable_d = xfer && !sel_x0;
    wfmode_d  = wfmode_q;
    wreg_d    = wreg_q;
    wdata_d   = wdata_q;
    if (xfer) begin
      wfmode_d = sel_fmode;
      wreg_d   = sel_reg;
      wdata_d  = sel_data;
    end
  end

  // Clear first, then set, so an issue on the same edge as the writeback wins.
  always_comb begin
    sb_d = sb_q;
    if (xfer && !sel_x0)     sb_d[{sel_fmode, sel_reg}] = 1'b0;
    if (iss_valid && !iss_x0) sb_d[{iss_fmode, iss_reg}] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wenable_q <= 1'b0;
      wfmode_q  <= 1'b0;
      wreg_q    <= 5'd0;
      wdata_q   <= 32'd0;
      sb_q      <= 64'd0;
    end else begin
      wenable_q <= wenable_d;
      wfmode_q  <= wfmode_d;
      wreg_q    <= wreg_d;
      wdata_q   <= wdata_d;
      sb_q      <= sb_d;
    end
  end

  // A write still in flight when reset asserts must not reach the register file.
  assign wenable = wenable_q & rstn;
  assign wfmode  = wfmode_q;
  assign wreg    = wreg_q;
  assign wdata   = wdata_q;

  assign busy1 = sb_q[{chk_fmode, chk_reg1}] & ~(~chk_fmode & (chk_reg1 == 5'd0));
  assign busy2 = sb_q[{chk_fmode, chk_reg2}] & ~(~chk_fmode & (chk_reg2 == 5'd0));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: grant vectors from a table, writeback results via an expectation queue.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rstn;
  logic [2:0]  req_valid;
  logic [2:0]  req_fmode;
  logic [14:0] req_reg;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wenable;
  logic        wfmode;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        iss_valid;
  logic        iss_fmode;
  logic [4:0]  iss_reg;
  logic        chk_fmode;
  logic [4:0]  chk_reg1;
  logic [4:0]  chk_reg2;
  logic        busy1;
  logic        busy2;

  regfile_wb_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_fmode(req_fmode), .req_reg(req_reg), .req_data(req_data),
    .req_ready(req_ready),
    .wenable(wenable), .wfmode(wfmode), .wreg(wreg), .wdata(wdata),
    .iss_valid(iss_valid), .iss_fmode(iss_fmode), .iss_reg(iss_reg),
    .chk_fmode(chk_fmode), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .busy1(busy1), .busy2(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  fmode;
    logic [14:0] rg;
    logic [95:0] data;
    logic [2:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic        we;
    logic        fm;
    logic [4:0]  rg;
    logic [31:0] dt;
  } wb_t;

  vec_t vecs[7];
  wb_t  exp_q[$];
  logic [2:0] exp_rr[6];

  int n_checks = 0;
  int n_pass   = 0;

  // Held writeback fields: what wfmode/wreg/wdata must show when no transfer happens.
  logic        h_fm;
  logic [4:0]  h_rg;
  logic [31:0] h_dt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_req(input int idx, input logic fm, input logic [4:0] rg, input logic [31:0] dt);
    req_fmode[idx]          = fm;
    req_reg[idx*5 +: 5]     = rg;
    req_data[idx*32 +: 32]  = dt;
  endtask

  task automatic cycle(input logic [2:0] exp_ready, input string nm);
    int  idx;
    wb_t e;
    #1;
    chk({nm, " ready"}, 32'(req_ready), 32'(exp_ready));
    e.we = 1'b0;
    if (exp_ready != 3'b000) begin
      idx  = exp_ready[0] ? 0 : (exp_ready[1] ? 1 : 2);
      h_fm = req_fmode[idx];
      h_rg = req_reg[idx*5 +: 5];
      h_dt = req_data[idx*32 +: 32];
      e.we = !(h_fm == 1'b0 && h_rg == 5'd0);
    end
    e.fm = h_fm;
    e.rg = h_rg;
    e.dt = h_dt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: expectation queue empty", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, " wenable"}, 32'(wenable), 32'(e.we));
      chk({nm, " wfmode"},  32'(wfmode),  32'(e.fm));
      chk({nm, " wreg"},    32'(wreg),    32'(e.rg));
      chk({nm, " wdata"},   wdata,        e.dt);
    end
  endtask

  task automatic do_reset(input logic [2:0] valid_during);
    rstn      = 1'b0;
    req_valid = valid_during;
    #1;
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset wenable", 32'(wenable), 32'd0);
    @(posedge clk);
    #1;
    h_fm = 1'b0;
    h_rg = 5'd0;
    h_dt = 32'd0;
    exp_q.delete();
    chk("post-reset wenable", 32'(wenable), 32'd0);
    chk("post-reset wfmode",  32'(wfmode),  32'd0);
    chk("post-reset wreg",    32'(wreg),    32'd0);
    chk("post-reset wdata",   wdata,        32'd0);
    rstn      = 1'b1;
    req_valid = 3'b000;
    iss_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; req_valid = '0; req_fmode = '0; req_reg = '0; req_data = '0;
    iss_valid = 1'b0; iss_fmode = 1'b0; iss_reg = '0;
    chk_fmode = 1'b0; chk_reg1 = '0; chk_reg2 = '0;
    h_fm = 1'b0; h_rg = '0; h_dt = '0;

    vecs[0] = '{3'b001, 3'b000, {5'd0, 5'd0, 5'd5},   {32'h0, 32'h0, 32'h12345678}, 3'b001};
    vecs[1] = '{3'b010, 3'b000, {5'd0, 5'd0, 5'd0},   {32'h0, 32'hDEAD0000, 32'h0}, 3'b010};
    vecs[2] = '{3'b110, 3'b010, {5'd4, 5'd0, 5'd0},   {32'h44, 32'hF0F0F0F0, 32'h0}, 3'b010};
    vecs[3] = '{3'b100, 3'b000, {5'd31, 5'd0, 5'd0},  {32'hA5A5A5A5, 32'h0, 32'h0}, 3'b100};
    vecs[4] = '{3'b101, 3'b101, {5'd9, 5'd0, 5'd1},   {32'h99, 32'h0, 32'h11}, 3'b001};
    vecs[5] = '{3'b000, 3'b111, {5'd7, 5'd7, 5'd7},   {32'h7, 32'h7, 32'h7}, 3'b000};
    vecs[6] = '{3'b111, 3'b010, {5'd3, 5'd2, 5'd1},   {32'h333, 32'h222, 32'h111}, 3'b001};

`ifdef WB_ROUND_ROBIN_EN
    exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100;
    exp_rr[3] = 3'b001; exp_rr[4] = 3'b010; exp_rr[5] = 3'b100;
`else
    for (int i = 0; i < 6; i++) exp_rr[i] = 3'b001;
`endif

    // Reset with everything asserted: no grant, no scoreboard set.
    iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd9;
    do_reset(3'b111);
    chk_fmode = 1'b0; chk_reg1 = 5'd9;
    #1;
    chk("reset sb int9", 32'(busy1), 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_reset(3'b000);
      req_valid = vecs[i].valid;
      req_fmode = vecs[i].fmode;
      req_reg   = vecs[i].rg;
      req_data  = vecs[i].data;
      cycle(vecs[i].exp_ready, $sformatf("vec%0d", i));
      req_valid = 3'b000;
      cycle(3'b000, $sformatf("vec%0d idle", i));
    end

    // All three requesting continuously from reset.
    do_reset(3'b000);
    set_req(0, 1'b0, 5'd1, 32'hAAAA0001);
    set_req(1, 1'b1, 5'd2, 32'hBBBB0002);
    set_req(2, 1'b0, 5'd3, 32'hCCCC0003);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) cycle(exp_rr[i], $sformatf("arb%0d", i));
    req_valid = 3'b000;

    // Scoreboard set / clear / collision.
    do_reset(3'b000);
    iss_valid = 1'b1; iss_fmode = 1'b1; iss_reg = 5'd3;
    cycle(3'b000, "iss f3");
    iss_valid = 1'b0;
    chk_fmode = 1'b1; chk_reg1 = 5'd3; chk_reg2 = 5'd4;
    #1;
    chk("sb f3 set", 32'(busy1), 32'd1);
    chk("sb f4 clear", 32'(busy2), 32'd0);
    set_req(2, 1'b1, 5'd3, 32'hCAFE0003);
    req_valid = 3'b100;
    #1;
    chk("sb no forward", 32'(busy1), 32'd1);
    cycle(3'b100, "mem f3");
    req_valid = 3'b000;
    #1;
    chk("sb f3 cleared", 32'(busy1), 32'd0);
    iss_valid = 1'b1;
    req_valid = 3'b100;
    cycle(3'b100, "set+clr f3");
    iss_valid = 1'b0;
    req_valid = 3'b000;
    #1;
    chk("sb set wins", 32'(busy1), 32'd1);
    iss_valid = 1'b1; iss_fmode = 1'b1; iss_reg = 5'd5;
    cycle(3'b000, "iss f5 a");
    cycle(3'b000, "iss f5 b");
    iss_valid = 1'b0;
    set_req(2, 1'b1, 5'd5, 32'h00000055);
    req_valid = 3'b100;
    cycle(3'b100, "mem f5");
    req_valid = 3'b000;
    chk_reg2 = 5'd5;
    #1;
    chk("sb no count", 32'(busy2), 32'd0);
    iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd0;
    cycle(3'b000, "iss x0");
    iss_valid = 1'b0;
    chk_fmode = 1'b0; chk_reg1 = 5'd0;
    #1;
    chk("sb x0", 32'(busy1), 32'd0);

    // Reset in the middle of traffic.
    do_reset(3'b000);
    iss_valid = 1'b1; iss_fmode = 1'b0; iss_reg = 5'd7;
    set_req(1, 1'b1, 5'd2, 32'h0F0F0F0F);
    req_valid = 3'b010;
    cycle(3'b010, "pre-rst fpu");
    iss_valid = 1'b0;
    chk_fmode = 1'b0; chk_reg1 = 5'd7;
    #1;
    chk("sb int7 set", 32'(busy1), 32'd1);
    set_req(0, 1'b0, 5'd4, 32'h00000004);
    set_req(2, 1'b0, 5'd8, 32'h00000008);
    do_reset(3'b101);
    #1;
    chk("sb int7 reset", 32'(busy1), 32'd0);
    req_valid = 3'b101;
    cycle(3'b001, "post-rst grant");
    req_valid = 3'b000;
    cycle(3'b000, "final idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
